// File: rtl/cpu_pkg.sv
// cpu_pkg: control bundle shared by the decode/execute, execute/memory and memory/writeback registers
package cpu_pkg;
  localparam int CTRL_ALUOP_W = 2;
  typedef struct packed {
    logic wbs;
    logic wme;
    logic mm;
    logic [CTRL_ALUOP_W-1:0] ALUop;
  } ctrl_t;
  localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones until reset
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;
  always_comb count_d = (inc && count_q != '1) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk) count_q <= !rst_n ? '0 : count_d;
  assign count = count_q;
endmodule

// File: rtl/decode_execute_pipe_reg.sv
// decode_execute_pipe_reg: decode->execute stage register with stall, flush and hazard event counters
module decode_execute_pipe_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int ALUOP_W    = CTRL_ALUOP_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic                  wbs_in,
  input  logic                  wme_in,
  input  logic                  mm_in,
  input  logic [ALUOP_W-1:0]    ALUop_in,
  input  logic [DATA_W-1:0]     rd1_in,
  input  logic [DATA_W-1:0]     rd2_in,
  input  logic [DATA_W-1:0]     imm_in,
  input  logic [REG_ADDR_W-1:0] rd_addr_in,
  output logic                  valid_out,
  output logic                  wbs_out,
  output logic                  wme_out,
  output logic                  mm_out,
  output logic [ALUOP_W-1:0]    ALUop_out,
  output logic [DATA_W-1:0]     rd1_out,
  output logic [DATA_W-1:0]     rd2_out,
  output logic [DATA_W-1:0]     imm_out,
  output logic [REG_ADDR_W-1:0] rd_addr_out,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  typedef struct packed {
    logic                  valid;
    ctrl_t                 ctrl;
    logic [DATA_W-1:0]     rd1;
    logic [DATA_W-1:0]     rd2;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] rd_addr;
  } stage_t;
  stage_t stage_q, stage_d;
  // a non-valid slot keeps its data but never carries control side effects
  always_comb
    stage_d = flush ? '0 :
              stall ? stage_q :
              stage_t'{valid_in, valid_in ? ctrl_t'{wbs_in, wme_in, mm_in, ALUop_in} : CTRL_BUBBLE,
                       rd1_in, rd2_in, imm_in, rd_addr_in};
  always_ff @(posedge clk) stage_q <= !rst_n ? '0 : stage_d;
  assign valid_out   = stage_q.valid;
  assign wbs_out     = stage_q.ctrl.wbs;
  assign wme_out     = stage_q.ctrl.wme;
  assign mm_out      = stage_q.ctrl.mm;
  assign ALUop_out   = stage_q.ctrl.ALUop;
  assign rd1_out     = stage_q.rd1;
  assign rd2_out     = stage_q.rd2;
  assign imm_out     = stage_q.imm;
  assign rd_addr_out = stage_q.rd_addr;
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (.clk(clk), .rst_n(rst_n), .inc(stall && !flush), .count(stall_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (.clk(clk), .rst_n(rst_n), .inc(flush), .count(flush_cnt));
endmodule

// File: tb/tb_decode_execute_pipe_reg.sv
// tb_decode_execute_pipe_reg: directed table, counter saturation sequences and a randomized model comparison
module tb_decode_execute_pipe_reg;
  typedef struct packed {
    logic v, wbs, wme, mm;
    logic [1:0] alu;
    logic [31:0] rd1, rd2, imm;
    logic [3:0] rd;
  } f_t;
  typedef struct {
    logic rst_n, stall, flush;
    f_t in;
    f_t exp;
    int sc, fc;
  } vec_t;
  logic clk = 0, rst_n, stall, flush, valid_in, wbs_in, wme_in, mm_in;
  logic [1:0] ALUop_in;
  logic [31:0] rd1_in, rd2_in, imm_in;
  logic [3:0] rd_addr_in;
  logic valid_out, wbs_out, wme_out, mm_out;
  logic [1:0] ALUop_out;
  logic [31:0] rd1_out, rd2_out, imm_out;
  logic [3:0] rd_addr_out;
  logic [15:0] stall_cnt, flush_cnt;
  logic s_valid_out, s_wbs_out, s_wme_out, s_mm_out;
  logic [1:0] s_ALUop_out;
  logic [31:0] s_rd1_out, s_rd2_out, s_imm_out;
  logic [3:0] s_rd_addr_out;
  logic [1:0] s_stall_cnt, s_flush_cnt;
  int n_cmp = 0, n_bad = 0;
  vec_t tbl[9];
  f_t m;
  int msc, mfc;
  always #5 clk = ~clk;
  decode_execute_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
    .wbs_in(wbs_in), .wme_in(wme_in), .mm_in(mm_in), .ALUop_in(ALUop_in),
    .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in), .rd_addr_in(rd_addr_in),
    .valid_out(valid_out), .wbs_out(wbs_out), .wme_out(wme_out), .mm_out(mm_out),
    .ALUop_out(ALUop_out), .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out),
    .rd_addr_out(rd_addr_out), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
  decode_execute_pipe_reg #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
    .wbs_in(wbs_in), .wme_in(wme_in), .mm_in(mm_in), .ALUop_in(ALUop_in),
    .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in), .rd_addr_in(rd_addr_in),
    .valid_out(s_valid_out), .wbs_out(s_wbs_out), .wme_out(s_wme_out), .mm_out(s_mm_out),
    .ALUop_out(s_ALUop_out), .rd1_out(s_rd1_out), .rd2_out(s_rd2_out), .imm_out(s_imm_out),
    .rd_addr_out(s_rd_addr_out), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic drive(input logic r, input logic s, input logic f, input f_t x);
    rst_n = r; stall = s; flush = f;
    {valid_in, wbs_in, wme_in, mm_in, ALUop_in, rd1_in, rd2_in, imm_in, rd_addr_in} = x;
  endtask
  function automatic int sat(input int v, input int mx);
    return v > mx ? mx : v;
  endfunction
  task automatic step_check(input string tag, input f_t e, input int sc, input int fc);
    @(posedge clk);
    #1;
    chk({tag, ".fields"}, {valid_out, wbs_out, wme_out, mm_out, ALUop_out, rd1_out, rd2_out, imm_out, rd_addr_out}, e);
    chk({tag, ".stall_cnt"}, stall_cnt, sat(sc, 65535));
    chk({tag, ".flush_cnt"}, flush_cnt, sat(fc, 65535));
    chk({tag, ".small_stall_cnt"}, s_stall_cnt, sat(sc, 3));
    chk({tag, ".small_flush_cnt"}, s_flush_cnt, sat(fc, 3));
  endtask
  initial begin
    f_t ld, ld2, inv;
    ld  = f_t'{1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 32'h11, 32'h22, 32'h5, 4'd3};
    ld2 = f_t'{1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 32'h33, 32'h44, 32'h6, 4'd9};
    inv = f_t'{1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 32'hAA, 32'hBB, 32'hCC, 4'd7};
    tbl[0] = '{1'b0, 1'b1, 1'b1, ld, '0, 0, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, ld, '0, 0, 0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, ld, ld, 0, 0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, ld2, ld, 1, 0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, ld2, ld, 2, 0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, ld2, ld, 3, 0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, ld2, '0, 3, 1};
    tbl[7] = '{1'b1, 1'b0, 1'b0, inv, f_t'{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'hAA, 32'hBB, 32'hCC, 4'd7}, 3, 1};
    tbl[8] = '{1'b0, 1'b1, 1'b0, ld, '0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].rst_n, tbl[i].stall, tbl[i].flush, tbl[i].in);
      step_check($sformatf("tbl%0d", i), tbl[i].exp, tbl[i].sc, tbl[i].fc);
    end
    drive(1'b1, 1'b0, 1'b0, ld);
    step_check("sat_load", ld, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, ld2);
      step_check($sformatf("sat_stall%0d", i), ld, i, 0);
    end
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, i[0], 1'b1, ld2);
      step_check($sformatf("sat_flush%0d", i), '0, 5, i);
    end
    drive(1'b0, 1'b1, 1'b1, ld2);
    step_check("sat_reset", '0, 0, 0);
    m = '0; msc = 0; mfc = 0;
    for (int i = 0; i < 400; i++) begin
      f_t x;
      logic r, s, f;
      x = {$urandom, $urandom, $urandom, $urandom};
      r = ($urandom_range(0, 31) != 0);
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 7) == 0);
      drive(r, s, f, x);
      if (!r) begin
        m = '0; msc = 0; mfc = 0;
      end else if (f) begin
        m = '0; mfc++;
      end else if (s) begin
        msc++;
      end else begin
        m = x;
        if (!x.v) {m.wbs, m.wme, m.mm, m.alu} = '0;
      end
      step_check($sformatf("rnd%0d", i), m, msc, mfc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
